// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: pops operand A, operand B and an opcode from the RX FIFO,
// drives the ALU, latches the result and pushes it (plus optional flags) to TX.
//
// Ports:
//   clk             system clock, rising edge
//   i_reset         synchronous active-low reset
//   i_rx_data       RX FIFO head word (first-word fall-through)
//   i_rx_empty      RX FIFO empty
//   o_rd            RX FIFO pop strobe
//   i_tx_full       TX FIFO full
//   o_wr            TX FIFO push strobe
//   o_tx_data       word presented to the TX FIFO
//   i_tx_done_tick  UART TX finished one word
//   o_op_a/o_op_b   ALU operands
//   o_op_code       ALU opcode (low NB_OP bits of the third word)
//   i_alu_result    ALU result (combinational)
//   i_alu_carry     ALU carry/borrow out
//   o_busy          high whenever not waiting for operand A
//   o_timeout       one-cycle pulse when a partial frame is abandoned
module uart_alu_sequencer #(
    parameter int NB_DATA    = 8,
    parameter int NB_OP      = 6,
    parameter int SEND_FLAGS = 0,
    parameter int TIMEOUT    = 0
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_empty,
    output logic               o_rd,
    input  logic               i_tx_full,
    output logic               o_wr,
    output logic [NB_DATA-1:0] o_tx_data,
    input  logic               i_tx_done_tick,
    output logic [NB_DATA-1:0] o_op_a,
    output logic [NB_DATA-1:0] o_op_b,
    output logic [NB_OP-1:0]   o_op_code,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_alu_carry,
    output logic               o_busy,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        GET_A, GET_B, GET_OP, EXEC,
        SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG
    } state_t;

    localparam int NB_WD = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [NB_WD-1:0] WD_LAST =
        NB_WD'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             state;
    state_t             state_next;
    logic [NB_DATA-1:0] result;
    logic [NB_DATA-1:0] flags;
    logic [NB_WD-1:0]   wd_cnt;
    logic               getting;
    logic               waiting;
    logic               sending;
    logic               pop;
    logic               push;
    logic               wd_fire;

    assign getting = (state == GET_A) || (state == GET_B) || (state == GET_OP);
    assign waiting = (state == GET_B) || (state == GET_OP);
    assign sending = (state == SEND_RES) || (state == SEND_FLG);

    // Strobes are gated by reset so a word is never lost on the reset edge.
    assign pop  = i_reset && getting && !i_rx_empty;
    assign push = i_reset && sending && !i_tx_full;

    // A word arriving on the last tolerated cycle wins over the watchdog.
    assign wd_fire = (TIMEOUT != 0) && waiting && i_rx_empty
                     && (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state <= GET_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            GET_A:    if (pop) state_next = GET_B;
            GET_B:    if (pop) state_next = GET_OP;
                      else if (wd_fire) state_next = GET_A;
            GET_OP:   if (pop) state_next = EXEC;
                      else if (wd_fire) state_next = GET_A;
            EXEC:     state_next = SEND_RES;
            SEND_RES: if (push) state_next = WAIT_RES;
            WAIT_RES: if (i_tx_done_tick)
                          state_next = (SEND_FLAGS != 0) ? SEND_FLG : GET_A;
            SEND_FLG: if (push) state_next = WAIT_FLG;
            WAIT_FLG: if (i_tx_done_tick) state_next = GET_A;
            default:  state_next = GET_A;
        endcase
    end

    always_comb begin
        o_rd      = pop;
        o_wr      = push;
        o_busy    = (state != GET_A);
        o_tx_data = ((state == SEND_FLG) || (state == WAIT_FLG)) ? flags : result;
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            o_op_a    <= '0;
            o_op_b    <= '0;
            o_op_code <= '0;
            result    <= '0;
            flags     <= '0;
            wd_cnt    <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= wd_fire;
            if (pop) begin
                unique case (state)
                    GET_A:   o_op_a    <= i_rx_data;
                    GET_B:   o_op_b    <= i_rx_data;
                    GET_OP:  o_op_code <= i_rx_data[NB_OP-1:0];
                    default: ;
                endcase
            end
            if (wd_fire) begin
                o_op_a <= '0;
            end
            if (state == EXEC) begin
                result <= i_alu_result;
                flags  <= {{(NB_DATA-2){1'b0}}, i_alu_carry, ~|i_alu_result};
            end
            if (pop || wd_fire || !waiting || (TIMEOUT == 0)) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + NB_WD'(1);
            end
        end
    end

endmodule

// File: doc/uart_alu_sequencer.md
# uart_alu_sequencer

Parametrised sequencer that sits between the UART RX/TX FIFOs and the combinational ALU, and replaces the fixed 8-bit operand interface. It pops operand A, operand B and an opcode from the RX FIFO, then drives the ALU and latches its result. It pushes the result to the TX FIFO, optionally followed by a flags byte. A watchdog abandons partially received operand sets.

## Interface

- NB_DATA, 8, UART word width and ALU operand/result width
- NB_OP, 6, opcode width; taken from the low NB_OP bits of the third received word (NB_OP <= NB_DATA)
- SEND_FLAGS, 0, 1 = transmit a flags byte after each result
- TIMEOUT, 0, idle cycles tolerated between operand words; 0 disables the watchdog
- clk  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_rx_data  in  NB_DATA  RX FIFO head word (first-word fall-through)
- i_rx_empty  in  1  RX FIFO empty
- o_rd  out  1  RX FIFO pop strobe
- i_tx_full  in  1  TX FIFO full
- o_wr  out  1  TX FIFO push strobe
- o_tx_data  out  NB_DATA  word to TX FIFO
- i_tx_done_tick  in  1  UART TX finished one word
- o_op_a  out  NB_DATA  ALU operand A
- o_op_b  out  NB_DATA  ALU operand B
- o_op_code  out  NB_OP  ALU opcode
- i_alu_result  in  NB_DATA  ALU result (combinational)
- i_alu_carry  in  1  ALU carry/borrow out
- o_busy  out  1  high whenever the state is not GET_A
- o_timeout  out  1  one-cycle pulse when the watchdog fires

## Operation

- States: GET_A, GET_B, GET_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG.
- Reset (i_reset=0 at an edge) → state GET_A. o_op_a, o_op_b, o_op_code, o_tx_data, the result register, the flags register and the watchdog counter are all 0.
- Reset applies from any state, including mid-frame. A partially received frame is discarded.
- **Operand capture.** In GET_A/GET_B/GET_OP, o_rd = !i_rx_empty (combinational, Moore-plus-empty). On that same edge, i_rx_data is latched into the matching register and the state advances.
  - No pop ever occurs outside these three states.
- **EXEC.** Lasts one cycle. i_alu_result is latched into the result register, which drives o_tx_data.
  - The flags register is set to {zeros, i_alu_carry, result==0}: bit1 = carry, bit0 = zero.
- **SEND_RES.** o_wr = !i_tx_full. When a push occurs → WAIT_RES.
- **WAIT_RES.** On i_tx_done_tick → SEND_FLG if SEND_FLAGS=1, else GET_A.
- **SEND_FLG / WAIT_FLG.** Same rules as SEND_RES/WAIT_RES, with o_tx_data = flags register. Then → GET_A.
- i_tx_done_tick is ignored outside WAIT_RES and WAIT_FLG.
- **Operand holding.** o_op_a, o_op_b and o_op_code hold their values until overwritten by the next frame.
- **Watchdog** (TIMEOUT>0):
  - The counter clears on every pop and while in GET_A. It increments each cycle in GET_B/GET_OP while i_rx_empty=1.
  - When the count reaches TIMEOUT-1 with the FIFO still empty: state → GET_A, o_op_a cleared, o_timeout=1 for one cycle.
  - If a word arrives in the same cycle the count reaches TIMEOUT-1, the pop wins and no timeout occurs.
  - TIMEOUT=0: the counter never fires.

## Timing

- o_rd and o_wr are each high for exactly one cycle per transferred word. There are never two consecutive pops of the same word.
- Opcode popped in cycle c → EXEC in c+1 → SEND_RES in c+2, with o_wr=1 in c+2 if the TX FIFO is not full.
- Back-to-back frames: if the RX FIFO holds 3 words, they are popped in 3 consecutive cycles.
- After i_tx_done_tick in the last wait state, the next frame's first pop can occur in the following cycle.
- A full TX FIFO stalls SEND_RES/SEND_FLG indefinitely. o_tx_data stays stable while stalled.
- o_busy and o_timeout are registered from state, with no combinational path from inputs.

## Test plan

- **ADD, no flags.** RX holds 0x05, 0x03, 0x20; ALU model add returns 0x08 → o_op_a=0x05, o_op_b=0x03, o_op_code=0x20. o_wr pulses once, 2 cycles after the opcode pop, with o_tx_data=0x08. Return to GET_A after a tick.
- **SEND_FLAGS=1.** Operands 0xFF, 0x01, add; result 0x00, carry 1 → two pushes: 0x00, then 0x03. The second push occurs only after the first i_tx_done_tick.
- **TX backpressure.** i_tx_full=1 for 10 cycles in SEND_RES → o_wr=0 and o_tx_data stable throughout. A single push occurs on the cycle full drops.
- **Watchdog.** TIMEOUT=16: push 0x11, then nothing → o_timeout pulses 16 cycles after entering GET_B, state returns to GET_A, o_op_a=0. A word arriving on exactly cycle 15 is accepted, with no timeout.
- **Reset mid-frame.** Assert i_reset=0 in GET_OP → next cycle all outputs are 0, o_busy=0, no o_rd. The next word is captured as operand A.
- **Streaming.** Two frames preloaded (6 words) → exactly 6 pops and 2 result pushes, with operands and results matching per frame.
